uart_rx_core: RTL

//  Serial UART receiver; the receive-side counterpart of the uart transmitter.

---
 rtl/uart_rx_if.sv | 23 ++
 rtl/uart_rx_core.sv | 124 ++++++++++++
 2 files changed

// File: rtl/uart_rx_if.sv
// uart_rx_if: bundle between uart_rx_core and its neighbours.
//  b_tick    : 1-clk 16x oversample enable from the baud tick generator
//  rx        : raw asynchronous serial line, idle high
//  rx_data   : last good byte, held until the next good frame
//  rx_busy   : high while a frame is in progress
//  rx_done   : 1-clk pulse, rx_data just updated
//  frame_err : 1-clk pulse, stop bit sampled low and the byte was dropped
// slave modport = the receiver, master modport = whoever drives the line/ticks.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 b_tick;
  logic                 rx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_busy;
  logic                 rx_done;
  logic                 frame_err;

  modport slave  (input  b_tick, rx,
                  output rx_data, rx_busy, rx_done, frame_err);
  modport master (output b_tick, rx,
                  input  rx_data, rx_busy, rx_done, frame_err);
endinterface

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1-style UART receiver with oversampled bit recovery.
//  i_clk : system clock, rising edge
//  i_rst : asynchronous active-low reset
//  bus   : uart_rx_if.slave (b_tick, rx in; rx_data, rx_busy, rx_done,
//          frame_err out)
// The line is double-flopped; every decision uses the synchronised copy.
// The start bit is confirmed at its middle, after which every sample lands
// a full bit period later, i.e. at the middle of each data bit and of the
// stop bit. Returning to IDLE at mid stop bit lets a back-to-back start edge
// in the second half of the stop bit be caught.
module uart_rx_core #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic     i_clk,
  input  logic     i_rst,
  uart_rx_if.slave bus
);
  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = (DATA_BITS  > 1) ? $clog2(DATA_BITS)  : 1;

  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE/2 - 1);
  localparam logic [TW-1:0] TICK_FULL = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]           r_sync;
  logic [1:0]           r_state;
  logic [TW-1:0]        r_tick;
  logic [BW-1:0]        r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_ferr;
  logic                 w_rx_s;

  assign w_rx_s = r_sync[1];

  // Synchroniser presets to 1 so reset looks like an idle line.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_sync <= 2'b11;
    else        r_sync <= {r_sync[0], bus.rx};
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
      r_tick  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_ferr <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Start edge is taken on any clock, not only on b_tick.
          r_tick <= '0;
          if (!w_rx_s) begin
            r_state <= S_START;
            r_busy  <= 1'b1;
          end
        end
        S_START: if (bus.b_tick) begin
          if (r_tick == TICK_HALF) begin
            r_tick <= '0;
            if (!w_rx_s) begin
              r_state <= S_DATA;
              r_bit   <= '0;
            end else begin
              // Line back high at mid start bit: a glitch, not a frame.
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_tick <= r_tick + TW'(1);
          end
        end
        S_DATA: if (bus.b_tick) begin
          if (r_tick == TICK_FULL) begin
            r_tick  <= '0;
            r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};  // LSB first
            if (r_bit == BIT_LAST) r_state <= S_STOP;
            else                   r_bit   <= r_bit + BW'(1);
          end else begin
            r_tick <= r_tick + TW'(1);
          end
        end
        S_STOP: if (bus.b_tick) begin
          if (r_tick == TICK_FULL) begin
            r_tick  <= '0;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            if (w_rx_s) begin
              r_data <= r_shift;
              r_done <= 1'b1;
            end else begin
              r_ferr <= 1'b1;
            end
          end else begin
            r_tick <= r_tick + TW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rx_data   = r_data;
  assign bus.rx_busy   = r_busy;
  assign bus.rx_done   = r_done;
  assign bus.frame_err = r_ferr;
endmodule
